logic_reduce_unit: RTL and testbench
====================================

# logic_reduce_unit

Parametrised, registered successor to the two-input OR primitive. Each accepted beat reduces N_IN lanes of WIDTH bits bit-wise with a selectable operator (AND/OR/XOR and their inversions). An optional accumulate mode folds successive beats of a packet into a single result. Results drain through a 2-entry output buffer with valid/ready handshakes, so the unit can sit between streaming producers and consumers in the datapath.

## Interface
- WIDTH, 8, bits per lane and result width.
- N_IN, 4, lanes per beat (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- A  in  N_IN*WIDTH  lane k = A[k*WIDTH +: WIDTH].
- OP  in  3  000 AND, 001 OR, 010 XOR, 100 NAND, 101 NOR, 110 XNOR; 011/111 decode as OR.
- MODE  in  1  0 single-shot, 1 accumulate.
- in_valid / in_last  in  1  beat valid / last beat of packet (ignored when MODE=0).
- in_ready  out  1  beat accepted when in_valid & in_ready.
- clr  in  1  synchronous flush of accumulator and buffer.
- Y  out  WIDTH  result.
- Y_ANY  out  1  |Y.
- out_valid  out  1  Y valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

## Operation
- Base op = OP[1:0] (AND/OR/XOR). Invert = OP[2]. R = base op across all N_IN lanes, per bit.
- MODE=0: each accepted beat pushes (Invert ? ~R : R).
- MODE=1: state first=1, acc.
  - Accepted non-last beat: acc ← first ? R : acc op R; first ← 0; no push.
  - Accepted last beat: push f = first ? R : acc op R, inverted if Invert; then first ← 1.
- OP is sampled on the first beat of a packet and held until the last beat. Mid-packet OP changes are ignored.
- MODE is sampled per beat. A MODE change mid-packet is a protocol error; its behaviour is undefined and untested.
- Buffer: 2-entry FIFO, order preserved. in_ready = (count < 2) & ~clr. This holds even for non-pushing beats.
- clr: count ← 0, first ← 1, out_valid ← 0. Any beat presented in the same cycle is discarded.
- Reset: count=0, first=1, acc=0, Y=0, Y_ANY=0, out_valid=0. in_ready goes to 1 on the first cycle after rst deasserts.

## Timing
- Latency: a pushing beat accepted at edge t gives out_valid=1 with Y valid after edge t (1 cycle), provided the buffer was empty.
- Throughput: 1 beat/cycle with out_ready held high.
- Push and pop in the same cycle at count=1: count stays 1 and the head advances.
- count=2: in_ready=0. Pop at edge t → in_ready=1 after t.
- Y/Y_ANY are held stable while out_valid & ~out_ready.
- Y_ANY is registered together with Y, not derived combinationally from the output.
- rst asserted mid-packet: the partial accumulation is lost immediately and no output is produced for it.

## Structure
- Package logic_reduce_pkg:
  - op_e enum (AND, OR, XOR, NAND, NOR, XNOR).
  - decode function: OP → {base, invert}, with reserved codes mapping to OR.
  - reduce function: lanes → R.
- Sub-module logic_reduce_fifo: parametrised WIDTH+1 (Y, Y_ANY), 2-entry, valid/ready on both sides, async active-high rst, sync clr.
- Top holds the decode, the reduction tree, the acc/first registers and the push logic.

## Test plan
- MODE=0, OR, lanes {0x01,0x02,0x04,0x80}, out_ready=1 → next cycle Y=0x87, Y_ANY=1, out_valid=1 for exactly 1 cycle.
- MODE=0, NOR, all lanes 0x00 → Y=0xFF. Then NAND with all lanes 0xFF → Y=0x00, Y_ANY=0.
- MODE=1, XOR, beats lane0 = 0x0F, 0xF0, then 0x01 with last (other lanes 0) → exactly one output, Y=0xFE. OP switched to AND on beat 2 has no effect.
- Backpressure: out_ready=0, 3 consecutive MODE=0 OR beats (0x11, 0x22, 0x33 in lane0) → in_ready falls after 2 acceptances. Release out_ready → outputs 0x11, 0x22, then 0x33, in order.
- rst pulse after 2 accumulate beats → out_valid=0 and Y=0 at once. A following single-beat last packet with AND, lanes all 0xA5, yields 0xA5 only.
- clr together with in_valid&in_last while the buffer holds 1 entry → next cycle out_valid=0, count=0, no output ever appears for that beat.

Source files
------------

// File: rtl/logic_reduce_pkg.sv
// logic_reduce_pkg: opcode types plus decode and per-bit lane reduction helpers
package logic_reduce_pkg;
  localparam int MAX_N = 16;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110
  } op_e;
  typedef enum logic [1:0] {B_AND, B_OR, B_XOR} base_e;
  typedef struct packed {
    base_e base;
    logic  inv;
  } dec_t;
  function automatic dec_t decode(input logic [2:0] op);
    dec_t d;
    d.base = op[1:0] == 2'b00 ? B_AND : op[1:0] == 2'b10 ? B_XOR : B_OR;
    d.inv  = op[2];
    return d;
  endfunction
  // Reduces one bit column across the first n lanes; lanes beyond n are masked out.
  function automatic logic reduce(input base_e b, input logic [MAX_N-1:0] col, input int n);
    logic [MAX_N-1:0] m;
    m = ~({MAX_N{1'b1}} << n);
    return b == B_AND ? &(col | ~m) : b == B_XOR ? ^(col & m) : |(col & m);
  endfunction
endpackage

// File: rtl/logic_reduce_unit_fifo.sv
// logic_reduce_unit_fifo: 2-entry valid/ready FIFO (clk, rst async, clr sync, in_*/out_* handshakes)
module logic_reduce_unit_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] cnt;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = mem[rp];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (clr) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) mem[wp] <= in_data;
      wp  <= wp ^ push;
      rp  <= rp ^ pop;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: registered N_IN-lane bitwise reducer with accumulate mode (A/OP/MODE beats in, Y/Y_ANY out via 2-entry buffer)
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] A,
  input  logic [2:0]            OP,
  input  logic                  MODE,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  clr,
  output logic [WIDTH-1:0]      Y,
  output logic                  Y_ANY,
  output logic                  out_valid,
  input  logic                  out_ready
);
  dec_t dec_in, op_q, eff;
  logic first, accept, push, fifo_rdy;
  logic [WIDTH-1:0] acc, r, comb, f, val;
  logic [WIDTH:0] fifo_out;
  assign dec_in = decode(OP);
  // Mid-packet beats use the operator captured on the packet's first beat.
  assign eff = (MODE & ~first) ? op_q : dec_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [MAX_N-1:0] col;
    for (genvar k = 0; k < MAX_N; k++) begin : g_lane
      if (k < N_IN) begin : g_on
        assign col[k] = A[k*WIDTH+i];
      end else begin : g_off
        assign col[k] = 1'b0;
      end
    end
    assign r[i] = reduce(eff.base, col, N_IN);
  end
  assign comb = first ? r : eff.base == B_AND ? acc & r : eff.base == B_XOR ? acc ^ r : acc | r;
  assign f = MODE ? comb : r;
  assign val = eff.inv ? ~f : f;
  assign in_ready = fifo_rdy & ~clr;
  assign accept = in_valid & in_ready;
  assign push = accept & (~MODE | in_last);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first <= 1'b1;
      acc   <= '0;
      op_q  <= '{base: B_AND, inv: 1'b0};
    end else if (clr) begin
      first <= 1'b1;
      acc   <= '0;
    end else if (accept & MODE) begin
      first <= in_last;
      op_q  <= eff;
      if (!in_last) acc <= comb;
    end
  end
  logic_reduce_unit_fifo #(.W(WIDTH + 1)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (push),
    .in_ready (fifo_rdy),
    .in_data  ({|val, val}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_out)
  );
  assign Y     = fifo_out[WIDTH-1:0];
  assign Y_ANY = fifo_out[WIDTH];
endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit: scoreboard bench for logic_reduce_unit
module tb_logic_reduce_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] A = '0;
  logic [2:0] OP = '0;
  logic MODE = 1'b0, in_valid = 1'b0, in_last = 1'b0, clr = 1'b0, out_ready = 1'b1;
  logic in_ready, Y_ANY, out_valid;
  logic [7:0] Y;
  logic [7:0] exp_q[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  logic_reduce_unit #(.WIDTH(8), .N_IN(4)) dut (
    .clk(clk), .rst(rst), .A(A), .OP(OP), .MODE(MODE), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .clr(clr), .Y(Y), .Y_ANY(Y_ANY),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Presents one beat, waits for acceptance, and queues its result when it pushes.
  task automatic beat(input logic [31:0] a, input logic [2:0] op, input logic mode,
                      input logic last, input logic [7:0] y, input logic pushes);
    bit ok = 0;
    A = a; OP = op; MODE = mode; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (pushes) exp_q.push_back(y);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {23'd0, Y_ANY, Y}, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("Y", Y, e);
        chk("Y_ANY", Y_ANY, |e);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clk); #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Y", Y, 0);
    chk("rst_Y_ANY", Y_ANY, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;
    // single-shot OR, one-cycle latency, single output pulse
    beat(32'h80040201, 3'b001, 0, 0, 8'h87, 1);
    @(negedge clk); chk("t1_valid", out_valid, 1);
    @(negedge clk); chk("t1_valid_drop", out_valid, 0);
    @(posedge clk); #1;
    beat(32'h00000000, 3'b101, 0, 0, 8'hFF, 1);
    beat(32'hFFFFFFFF, 3'b100, 0, 0, 8'h00, 1);
    beat(32'h00000F0F, 3'b110, 0, 0, 8'hFF, 1);
    beat(32'h7FF3FFF0, 3'b000, 0, 0, 8'h70, 1);
    beat(32'h80040201, 3'b011, 0, 0, 8'h87, 1);
    beat(32'h80040201, 3'b111, 0, 0, 8'h78, 1);
    // accumulate XOR; later OP changes are ignored
    beat(32'h0000000F, 3'b010, 1, 0, 8'h00, 0);
    beat(32'h000000F0, 3'b000, 1, 0, 8'h00, 0);
    beat(32'h00000001, 3'b000, 1, 1, 8'hFE, 1);
    beat(32'h00000201, 3'b101, 1, 0, 8'h00, 0);
    beat(32'h00400000, 3'b101, 1, 1, 8'hBC, 1);
    // backpressure
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    beat(32'h00000011, 3'b001, 0, 0, 8'h11, 1);
    beat(32'h00000022, 3'b001, 0, 0, 8'h22, 1);
    A = 32'h33; in_valid = 1'b1;
    @(negedge clk); chk("bp_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp_hold_Y", Y, 8'h11);
    chk("bp_hold_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    beat(32'h00000033, 3'b001, 0, 0, 8'h33, 1);
    repeat (4) @(posedge clk);
    // reset mid-packet with a buffered entry
    #1 out_ready = 1'b0;
    beat(32'h0000003C, 3'b001, 0, 0, 8'h00, 0);
    beat(32'h00000055, 3'b010, 1, 0, 8'h00, 0);
    beat(32'h0000000F, 3'b010, 1, 0, 8'h00, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_Y", Y, 0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    beat(32'hA5A5A5A5, 3'b000, 1, 1, 8'hA5, 1);
    repeat (3) @(posedge clk);
    // clr with a buffered entry and a concurrent last beat
    #1 out_ready = 1'b0;
    beat(32'h00000033, 3'b010, 1, 0, 8'h00, 0);
    beat(32'h00000042, 3'b001, 0, 0, 8'h00, 0);
    A = 32'h99999999; OP = 3'b001; MODE = 1'b1; in_last = 1'b1; in_valid = 1'b1; clr = 1'b1;
    @(negedge clk); chk("clr_in_ready", in_ready, 0);
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); chk("clr_valid", out_valid, 0);
    chk("clr_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 beat(32'h00000007, 3'b010, 1, 1, 8'h07, 1);
    repeat (5) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
